// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 4-register, 8-bit cpu datapath.
// Fetches an instruction, then steps it through DECODE, EXEC and WB while tracking pc and retired count.
module cpu_ctrl_fsm #(
    parameter int          PC_W      = 8,
    parameter int          CNT_W     = 16,
    parameter logic [7:0]  HALT_INST = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [7:0]       imem_rdata,
    input  logic             imem_valid,
    output logic [1:0]       src1_addr,
    output logic [1:0]       src2_addr,
    output logic [1:0]       op,
    output logic [1:0]       dest_addr,
    output logic             rf_we,
    output logic             busy,
    output logic             halted,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 8'h00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = (ir_q == HALT_INST) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                busy  = 1'b1;
                rf_we = 1'b1;
                pc_d  = pc_q + PC_W'(1);
                // Counter sticks at all-ones rather than wrapping back to zero.
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign op        = ir_q[7:6];
    assign src1_addr = ir_q[5:4];
    assign src2_addr = ir_q[3:2];
    assign dest_addr = ir_q[1:0];

endmodule
